// File: rtl/lcd_st_timing_adapter.sv
// Avalon-ST timing adapter: upstream with ready latency IN_READY_LATENCY to a
// downstream ready-latency-0 interface through a credit-controlled show-ahead FIFO.
// Optional build macro LCD_ST_TIMING_ADAPTER_OVF_EN adds sticky overflow and a
// saturating dropped-beat counter.
module lcd_st_timing_adapter #(
  parameter int unsigned DATA_W           = 8,
  parameter int unsigned IN_READY_LATENCY = 0,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
`ifdef LCD_ST_TIMING_ADAPTER_OVF_EN
  ,
  output logic                          overflow,
  output logic [7:0]                    drop_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((FIFO_DEPTH < IN_READY_LATENCY + 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (IN_READY_LATENCY > 4) || (DATA_W < 1) || (DATA_W > 64)) begin : g_param_check
    $error("lcd_st_timing_adapter: illegal parameter combination");
  end

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              push, pop, full, drop;
  logic [CW-1:0]     space_d;

  // Handshake decode, occupancy update and credit computation.
  always_comb begin
    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = (count_q != '0) && out_ready;
    // A full FIFO still accepts a beat if a slot frees up in the same cycle.
    push     = in_valid && (!full || pop);
    drop     = in_valid && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    space_d  = CW'(FIFO_DEPTH) - count_d;
    // Leave room for the beats already in flight on the latency pipe.
    in_ready_d = (space_d >= CW'(IN_READY_LATENCY + 2));
  end

  // Pointer, occupancy and credit registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Payload storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Show-ahead outputs straight from registered state.
  always_comb begin
    out_valid  = (count_q != '0);
    out_data   = mem[rd_ptr_q];
    fill_level = count_q;
    in_ready   = in_ready_q;
  end

`ifdef LCD_ST_TIMING_ADAPTER_OVF_EN
  logic       overflow_q;
  logic [7:0] drop_count_q;

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_count_q != 8'hFF) begin
        drop_count_q <= drop_count_q + 8'd1;
      end
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
